// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC receive-RAM readout path.
package adc_pkg;

   localparam int ADC_WORD_W = 128;
   localparam int BEAT_W     = 32;
   localparam int RAM_WORDS  = 16384;
   localparam int WCNT_W     = 15;
   localparam int LEN_W      = 16;

   typedef enum logic [1:0] {
      RD_IDLE,
      RD_RUN,
      RD_DRAIN
   } rd_state_t;

   // Requested record length limited to the RAM capacity; 16384 fits in 15 bits
   function automatic logic [WCNT_W-1:0] clamp_words(input logic [LEN_W-1:0] len);
      if (len > LEN_W'(RAM_WORDS)) begin
         return WCNT_W'(RAM_WORDS);
      end
      return WCNT_W'(len);
   endfunction

endpackage

// File: rtl/adc_prefetch_fifo.sv
// Small synchronous FIFO holding RAM words between the read port and the beat unpacker.
module adc_prefetch_fifo #(
   parameter int WIDTH = 128,
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             iReset_n,
   input  logic             iFlush,
   input  logic             iPush,
   input  logic [WIDTH-1:0] iData,
   input  logic             iPop,
   output logic [WIDTH-1:0] oData,
   output logic [CNT_W-1:0] oCount,
   output logic             oEmpty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign do_push = iPush && (count != CNT_W'(DEPTH));
   assign do_pop  = iPop && (count != '0);

   // Pointer and occupancy bookkeeping; a flush empties the FIFO in one cycle
   always_ff @(posedge clk or negedge iReset_n) begin
      if (!iReset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (iFlush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage array, written only on an accepted push
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= iData;
      end
   end

   assign oData  = mem[rd_ptr];
   assign oCount = count;
   assign oEmpty = (count == '0);

endmodule

// File: rtl/adc_ram_readout.sv
// Reads captured 128-bit sample words from RAM port B and streams them as 32-bit beats.
module adc_ram_readout
   import adc_pkg::*;
#(
   parameter int RD_LAT     = 2,
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_W     = 15
) (
   input  logic                  clk,
   input  logic                  iReset_n,
   input  logic                  iStartRead,
   input  logic                  iAbort,
   input  logic [LEN_W-1:0]      iRecLength,
   output logic [ADDR_W-1:0]     oRAddr,
   output logic                  oRdEn,
   input  logic [ADC_WORD_W-1:0] iRamData,
   output logic [BEAT_W-1:0]     oData,
   output logic                  oValid,
   input  logic                  iReady,
   output logic                  oLast,
   output logic                  oBusy,
   output logic                  oDone
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   rd_state_t             state;
   rd_state_t             state_nxt;
   logic [WCNT_W-1:0]     words_q;
   logic [WCNT_W-1:0]     issued_q;
   logic [WCNT_W-1:0]     popped_q;
   logic [WCNT_W-1:0]     start_words;
   logic [1:0]            beat_q;
   logic [RD_LAT-1:0]     vld_pipe;
   logic                  done_q;
   logic [CNT_W-1:0]      fifo_count;
   logic                  fifo_empty;
   logic [ADC_WORD_W-1:0] head_word;
   logic [7:0]            in_flight;
   logic [7:0]            credit_used;
   logic                  start_acc;
   logic                  beat_acc;
   logic                  word_pop;
   logic                  last_acc;
   logic                  rd_en;
   logic                  valid_int;
   logic                  last_int;

   assign start_words = clamp_words(iRecLength);
   assign start_acc   = (state == RD_IDLE) && iStartRead && !iAbort;
   assign beat_acc    = valid_int && iReady;
   assign word_pop    = beat_acc && (beat_q == 2'd3);
   assign last_acc    = beat_acc && last_int;
   assign credit_used = 8'(fifo_count) + in_flight;

   // Count reads issued but not yet returned by the RAM
   always_comb begin
      in_flight = '0;
      for (int i = 0; i < RD_LAT; i++) begin
         in_flight = in_flight + 8'(vld_pipe[i]);
      end
   end

   // State register
   always_ff @(posedge clk or negedge iReset_n) begin
      if (!iReset_n) begin
         state <= RD_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; abort overrides everything and a zero-length start never leaves IDLE
   always_comb begin
      state_nxt = state;
      case (state)
         RD_IDLE: begin
            if (start_acc && (start_words != '0)) begin
               state_nxt = RD_RUN;
            end
         end
         RD_RUN: begin
            if (last_acc) begin
               state_nxt = RD_IDLE;
            end else if (issued_q == words_q) begin
               state_nxt = RD_DRAIN;
            end
         end
         RD_DRAIN: begin
            if (last_acc) begin
               state_nxt = RD_IDLE;
            end
         end
         default: state_nxt = RD_IDLE;
      endcase
      if (iAbort) begin
         state_nxt = RD_IDLE;
      end
   end

   // Outputs: reads are issued only while FIFO space covers everything already in flight
   always_comb begin
      oBusy     = (state != RD_IDLE);
      rd_en     = (state == RD_RUN) && (issued_q < words_q) && (credit_used < 8'(FIFO_DEPTH));
      valid_int = (state != RD_IDLE) && !fifo_empty;
      last_int  = valid_int && (beat_q == 2'd3) && (popped_q == words_q - WCNT_W'(1));
      oData     = '0;
      if (valid_int) begin
         case (beat_q)
            2'd0:    oData = head_word[127:96];
            2'd1:    oData = head_word[95:64];
            2'd2:    oData = head_word[63:32];
            default: oData = head_word[31:0];
         endcase
      end
   end

   // Word/beat counters, read-latency tracker and the completion pulse
   always_ff @(posedge clk or negedge iReset_n) begin
      if (!iReset_n) begin
         words_q  <= '0;
         issued_q <= '0;
         popped_q <= '0;
         beat_q   <= '0;
         vld_pipe <= '0;
         done_q   <= 1'b0;
      end else if (iAbort) begin
         issued_q <= '0;
         popped_q <= '0;
         beat_q   <= '0;
         vld_pipe <= '0;
         done_q   <= 1'b0;
      end else begin
         vld_pipe[0] <= rd_en;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
         end
         done_q <= last_acc || (start_acc && (start_words == '0));
         if (start_acc) begin
            words_q  <= start_words;
            issued_q <= '0;
            popped_q <= '0;
            beat_q   <= '0;
         end else begin
            if (rd_en) begin
               issued_q <= issued_q + WCNT_W'(1);
            end
            if (beat_acc) begin
               beat_q <= beat_q + 2'd1;
               if (beat_q == 2'd3) begin
                  popped_q <= popped_q + WCNT_W'(1);
               end
            end
         end
      end
   end

   adc_prefetch_fifo #(
      .WIDTH (ADC_WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .iReset_n (iReset_n),
      .iFlush   (iAbort),
      .iPush    (vld_pipe[RD_LAT-1]),
      .iData    (iRamData),
      .iPop     (word_pop),
      .oData    (head_word),
      .oCount   (fifo_count),
      .oEmpty   (fifo_empty)
   );

   assign oRAddr = ADDR_W'(issued_q);
   assign oRdEn  = rd_en;
   assign oValid = valid_int;
   assign oLast  = last_int;
   assign oDone  = done_q;

endmodule

// File: tb/tb_adc_ram_readout.sv
// Directed bench for adc_ram_readout with a latency-accurate RAM model.
module tb_adc_ram_readout;

   localparam int RD_LAT     = 2;
   localparam int FIFO_DEPTH = 4;
   localparam int ADDR_W     = 15;

   logic          clk = 1'b0;
   logic          iReset_n;
   logic          iStartRead;
   logic          iAbort;
   logic [15:0]   iRecLength;
   logic [14:0]   oRAddr;
   logic          oRdEn;
   logic [127:0]  iRamData;
   logic [31:0]   oData;
   logic          oValid;
   logic          iReady;
   logic          oLast;
   logic          oBusy;
   logic          oDone;

   int testsRun = 0;
   int testsFailed = 0;
   int beatIdx;
   int firstValidWait;
   int bubbles;
   int maxOutstanding;
   int readsIssued;
   int addrErrs;
   int expAddr;
   int readCnt [32];

   logic [127:0] ramPipe [RD_LAT];

   always #5 clk = ~clk;

   adc_ram_readout #(
      .RD_LAT     (RD_LAT),
      .FIFO_DEPTH (FIFO_DEPTH),
      .ADDR_W     (ADDR_W)
   ) dut (
      .clk        (clk),
      .iReset_n   (iReset_n),
      .iStartRead (iStartRead),
      .iAbort     (iAbort),
      .iRecLength (iRecLength),
      .oRAddr     (oRAddr),
      .oRdEn      (oRdEn),
      .iRamData   (iRamData),
      .oData      (oData),
      .oValid     (oValid),
      .iReady     (iReady),
      .oLast      (oLast),
      .oBusy      (oBusy),
      .oDone      (oDone)
   );

   // RAM port B: word k holds k in every channel, returned RD_LAT clocks after the read
   always @(posedge clk) begin
      ramPipe[0] <= oRdEn ? {8{16'(oRAddr)}} : 128'd0;
      for (int i = 1; i < RD_LAT; i++) begin
         ramPipe[i] <= ramPipe[i-1];
      end
   end
   assign iRamData = ramPipe[RD_LAT-1];

   // Log each read the DUT is about to issue and verify addresses run 0,1,2,...
   always @(negedge clk) begin
      if (iReset_n && oRdEn) begin
         if (oRAddr < 15'd32) begin
            readCnt[oRAddr] = readCnt[oRAddr] + 1;
         end
         if (int'(oRAddr) != expAddr) begin
            addrErrs = addrErrs + 1;
         end
         expAddr     = expAddr + 1;
         readsIssued = readsIssued + 1;
      end
   end

   // Hard stop in case the DUT wedges somewhere outside a bounded wait
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed no finish, expected finish before 500000");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Pulse start with a length; returns one clock later with read bookkeeping cleared
   task automatic applyStimulus(input logic [15:0] len);
      foreach (readCnt[i]) readCnt[i] = 0;
      readsIssued    = 0;
      addrErrs       = 0;
      expAddr        = 0;
      maxOutstanding = 0;
      beatIdx        = 0;
      iRecLength     = len;
      iStartRead     = 1'b1;
      @(negedge clk);
      iStartRead     = 1'b0;
   endtask

   // Accept beats up to index target, checking data, oLast and hold-while-stalled
   task automatic collectBeats(input string tag, input int target, input int recWords,
                               input bit randomReady, input int budget);
      int          cyc;
      int          outstanding;
      bit          held;
      logic [31:0] heldData;
      logic        heldLast;
      logic [15:0] w;
      cyc = 0;
      held = 1'b0;
      heldData = '0;
      heldLast = 1'b0;
      firstValidWait = -1;
      bubbles = 0;
      while (beatIdx < target && cyc < budget) begin
         outstanding = readsIssued - beatIdx / 4;
         if (outstanding > maxOutstanding) maxOutstanding = outstanding;
         if (held) begin
            checkOutput({tag, "_stall_valid"}, oValid, 1'b1);
            checkOutput({tag, "_stall_data"}, oData, heldData);
            checkOutput({tag, "_stall_last"}, oLast, heldLast);
         end
         iReady = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
         if (oValid) begin
            if (firstValidWait < 0) firstValidWait = cyc;
            if (iReady) begin
               w = 16'(beatIdx / 4);
               checkOutput({tag, "_beat_data"}, oData, {w, w});
               checkOutput({tag, "_beat_last"}, oLast, (beatIdx == 4 * recWords - 1));
               beatIdx++;
               held = 1'b0;
            end else begin
               held = 1'b1;
               heldData = oData;
               heldLast = oLast;
            end
         end else if (firstValidWait >= 0) begin
            bubbles++;
         end
         @(negedge clk);
         cyc++;
      end
      checkOutput({tag, "_beat_count"}, beatIdx, target);
   endtask

   // Directed sequence: reset, short records, backpressure, zero length, abort, reset/clamp
   initial begin
      bit sawRdEn;
      bit sawValid;
      bit sawBusy;
      bit sawDone;
      iReset_n = 1'b0;
      iStartRead = 1'b0;
      iAbort = 1'b0;
      iRecLength = '0;
      iReady = 1'b0;
      foreach (readCnt[i]) readCnt[i] = 0;
      readsIssued = 0;
      addrErrs = 0;
      expAddr = 0;
      repeat (3) @(negedge clk);

      checkOutput("rst_raddr", oRAddr, 15'd0);
      checkOutput("rst_rden", oRdEn, 1'b0);
      checkOutput("rst_valid", oValid, 1'b0);
      checkOutput("rst_data", oData, 32'd0);
      checkOutput("rst_last", oLast, 1'b0);
      checkOutput("rst_busy", oBusy, 1'b0);
      checkOutput("rst_done", oDone, 1'b0);
      iReset_n = 1'b1;
      @(negedge clk);

      $display("[TB] one-word record");
      applyStimulus(16'd1);
      checkOutput("t1_busy", oBusy, 1'b1);
      collectBeats("t1", 4, 1, 1'b0, 200);
      checkOutput("t1_first_valid", firstValidWait, RD_LAT + 1);
      checkOutput("t1_done", oDone, 1'b1);
      checkOutput("t1_busy_off", oBusy, 1'b0);
      @(negedge clk);
      checkOutput("t1_done_pulse", oDone, 1'b0);

      $display("[TB] three-word record at full rate");
      applyStimulus(16'd3);
      collectBeats("t2", 12, 3, 1'b0, 200);
      checkOutput("t2_bubbles", bubbles, 0);
      checkOutput("t2_first_valid", firstValidWait, RD_LAT + 1);
      checkOutput("t2_rd0", readCnt[0], 1);
      checkOutput("t2_rd1", readCnt[1], 1);
      checkOutput("t2_rd2", readCnt[2], 1);
      checkOutput("t2_rd3", readCnt[3], 0);
      checkOutput("t2_addr_order", addrErrs, 0);
      checkOutput("t2_done", oDone, 1'b1);

      $display("[TB] eight-word record with random backpressure");
      applyStimulus(16'd8);
      collectBeats("t3", 32, 8, 1'b1, 2000);
      checkOutput("t3_credit", (maxOutstanding <= FIFO_DEPTH), 1'b1);
      checkOutput("t3_reads", readsIssued, 8);
      checkOutput("t3_done", oDone, 1'b1);
      @(negedge clk);

      $display("[TB] zero-length record");
      iReady = 1'b1;
      applyStimulus(16'd0);
      checkOutput("t4_done", oDone, 1'b1);
      sawRdEn = 1'b0;
      sawValid = 1'b0;
      sawBusy = 1'b0;
      for (int i = 0; i < 6; i++) begin
         sawRdEn |= oRdEn;
         sawValid |= oValid;
         sawBusy |= oBusy;
         @(negedge clk);
         if (i == 0) checkOutput("t4_done_pulse", oDone, 1'b0);
      end
      checkOutput("t4_no_rden", sawRdEn, 1'b0);
      checkOutput("t4_no_valid", sawValid, 1'b0);
      checkOutput("t4_no_busy", sawBusy, 1'b0);

      $display("[TB] abort mid-record then restart");
      applyStimulus(16'd100);
      collectBeats("t5", 50, 100, 1'b0, 400);
      iReady = 1'b0;
      iAbort = 1'b1;
      @(negedge clk);
      iAbort = 1'b0;
      checkOutput("t5_valid_off", oValid, 1'b0);
      checkOutput("t5_busy_off", oBusy, 1'b0);
      sawDone = 1'b0;
      sawValid = 1'b0;
      for (int i = 0; i < 12; i++) begin
         sawDone |= oDone;
         sawValid |= oValid;
         @(negedge clk);
      end
      checkOutput("t5_no_done", sawDone, 1'b0);
      checkOutput("t5_idle_valid", sawValid, 1'b0);
      applyStimulus(16'd2);
      collectBeats("t5b", 8, 2, 1'b0, 200);
      checkOutput("t5b_done", oDone, 1'b1);
      checkOutput("t5b_addr_order", addrErrs, 0);
      checkOutput("t5b_reads", readsIssued, 2);

      $display("[TB] start while busy, reset mid-record, length clamp");
      applyStimulus(16'd20);
      collectBeats("t6", 6, 20, 1'b0, 200);
      iReady = 1'b0;
      iRecLength = 16'd5;
      iStartRead = 1'b1;
      @(negedge clk);
      iStartRead = 1'b0;
      checkOutput("t6_still_busy", oBusy, 1'b1);
      collectBeats("t6b", 14, 20, 1'b0, 200);
      checkOutput("t6_addr_order", addrErrs, 0);
      iReset_n = 1'b0;
      #1;
      checkOutput("t6_rst_raddr", oRAddr, 15'd0);
      checkOutput("t6_rst_rden", oRdEn, 1'b0);
      checkOutput("t6_rst_valid", oValid, 1'b0);
      checkOutput("t6_rst_data", oData, 32'd0);
      checkOutput("t6_rst_last", oLast, 1'b0);
      checkOutput("t6_rst_busy", oBusy, 1'b0);
      checkOutput("t6_rst_done", oDone, 1'b0);
      @(negedge clk);
      iReset_n = 1'b1;
      @(negedge clk);
      iReady = 1'b1;
      applyStimulus(16'hFFFF);
      checkOutput("t6_clamp_busy", oBusy, 1'b1);
      checkOutput("t6_clamp_rden", oRdEn, 1'b1);
      checkOutput("t6_clamp_addr", oRAddr, 15'd0);
      collectBeats("t6c", 8, 16384, 1'b0, 200);
      checkOutput("t6c_addr_order", addrErrs, 0);
      iAbort = 1'b1;
      @(negedge clk);
      iAbort = 1'b0;
      checkOutput("t6_clamp_abort", oBusy, 1'b0);
      applyStimulus(16'h4000);
      checkOutput("t6_full_busy", oBusy, 1'b1);
      iAbort = 1'b1;
      @(negedge clk);
      iAbort = 1'b0;
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
